// File: rtl/a2d_pkg.sv
// ============================================================================
// a2d_pkg : shared types and defaults for the A2D scan controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package a2d_pkg;

  localparam int c_NUM_CH      = 8;
  localparam int c_SCAN_PERIOD = 50000;
  localparam int c_TMO         = 2048;
  localparam int c_RES_W       = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_CC = 2'd2,
    NEXT    = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/scan_timer.sv
// ============================================================================
// scan_timer : free-running period counter, pulses o_wrap once per PERIOD
// Revision: 1.0
// ============================================================================
`default_nettype none

module scan_timer
  import a2d_pkg::*;
#(
  parameter int PERIOD = c_SCAN_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_wrap
);

  localparam int                 c_CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PERIOD - 1);

  logic [c_CNT_W-1:0] r_cnt;

  // Held at zero while disabled so a re-enable always waits a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || (r_cnt == c_CNT_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_wrap = i_en && (r_cnt == c_CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/a2d_scan_ctrl.sv
// ============================================================================
// a2d_scan_ctrl : periodic multi-channel A2D scanner with on-demand requests
// Revision: 1.0
// ============================================================================
`default_nettype none

module a2d_scan_ctrl
  import a2d_pkg::*;
#(
  parameter int NUM_CH      = c_NUM_CH,
  parameter int SCAN_PERIOD = c_SCAN_PERIOD,
  parameter int TMO         = c_TMO
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               strt_cnv,
  output logic [2:0]         chnnl,
  input  logic               cnv_cmplt,
  input  logic [c_RES_W-1:0] res,
  input  logic [2:0]         rd_ch,
  output logic [c_RES_W-1:0] rd_data,
  output logic [7:0]         vld,
  input  logic               req,
  input  logic [2:0]         req_ch,
  output logic               req_ack,
  output logic [c_RES_W-1:0] req_res,
  output logic               scan_done,
  output logic               tmo_err
);

  localparam logic [2:0]         c_LAST_CH  = 3'(NUM_CH - 1);
  localparam int                 c_TMO_W    = $clog2(TMO + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TMO - 1);

  state_t               r_state;
  logic                 r_pend;
  logic                 r_scan_act;
  logic                 r_is_req;
  logic [2:0]           r_scan_ch;
  logic [c_TMO_W-1:0]   r_tmo_cnt;
  logic [c_RES_W-1:0]   r_tbl [NUM_CH];

  logic w_wrap;
  logic w_req_ok;
  logic w_scan_start;

  scan_timer #(
    .PERIOD (SCAN_PERIOD)
  ) u_scan_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (en),
    .o_wrap (w_wrap)
  );

  // A request still high while its ack is showing is the one just served.
  assign w_req_ok     = req && !req_ack;
  assign w_scan_start = (r_state == IDLE) && !w_req_ok && r_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pend     <= 1'b0;
      r_scan_act <= 1'b0;
      r_is_req   <= 1'b0;
      r_scan_ch  <= '0;
      r_tmo_cnt  <= '0;
      strt_cnv   <= 1'b0;
      chnnl      <= '0;
      vld        <= '0;
      req_ack    <= 1'b0;
      req_res    <= '0;
      scan_done  <= 1'b0;
      tmo_err    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_tbl[i] <= '0;
    end else begin
      strt_cnv  <= 1'b0;
      req_ack   <= 1'b0;
      scan_done <= 1'b0;

      if (!en)               r_pend <= 1'b0;
      else if (w_wrap)       r_pend <= 1'b1;
      else if (w_scan_start) r_pend <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_req_ok) begin
            chnnl    <= req_ch;
            r_is_req <= 1'b1;
            strt_cnv <= 1'b1;
            r_state  <= START;
          end else if (r_pend) begin
            chnnl      <= '0;
            r_scan_ch  <= '0;
            r_scan_act <= 1'b1;
            r_is_req   <= 1'b0;
            strt_cnv   <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          r_tmo_cnt <= '0;
          r_state   <= WAIT_CC;
        end
        WAIT_CC: begin
          if (cnv_cmplt) begin
            if (r_is_req) begin
              req_res <= res;
              req_ack <= 1'b1;
            end else begin
              for (int i = 0; i < NUM_CH; i++) begin
                if (chnnl == 3'(i)) begin
                  r_tbl[i] <= res;
                  vld[i]   <= 1'b1;
                end
              end
            end
            r_state <= NEXT;
          end else if (r_tmo_cnt == c_TMO_LAST) begin
            tmo_err <= 1'b1;
            if (r_is_req) begin
              req_res <= '0;
              req_ack <= 1'b1;
            end
            r_state <= NEXT;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        NEXT: begin
          if (w_req_ok) begin
            chnnl    <= req_ch;
            r_is_req <= 1'b1;
            strt_cnv <= 1'b1;
            r_state  <= START;
          end else if (r_scan_act && (r_scan_ch < c_LAST_CH)) begin
            chnnl     <= r_scan_ch + 3'd1;
            r_scan_ch <= r_scan_ch + 3'd1;
            r_is_req  <= 1'b0;
            strt_cnv  <= 1'b1;
            r_state   <= START;
          end else begin
            scan_done  <= r_scan_act;
            r_scan_act <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == 3'(i)) rd_data = r_tbl[i];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_a2d_scan_ctrl.sv
// ============================================================================
// tb_a2d_scan_ctrl : self-checking bench with A2D models and a start/ack scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_a2d_scan_ctrl;
  import a2d_pkg::*;

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] data;
  } rd_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, req;
  logic [2:0]  rd_ch, req_ch;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] res = '0;
  logic        strt_cnv, req_ack, scan_done, tmo_err;
  logic [2:0]  chnnl;
  logic [11:0] rd_data, req_res;
  logic [7:0]  vld;

  logic        en_b, req_b;
  logic [2:0]  rd_ch_b, req_ch_b;
  logic        cmplt_b = 1'b0;
  logic [11:0] res_b = '0;
  logic        strt_b, req_ack_b, scan_done_b, tmo_b;
  logic [2:0]  ch_b;
  logic [11:0] rd_data_b, req_res_b;
  logic [7:0]  vld_b;

  a2d_scan_ctrl #(.NUM_CH(8), .SCAN_PERIOD(100), .TMO(2048)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .res(res), .rd_ch(rd_ch), .rd_data(rd_data), .vld(vld),
    .req(req), .req_ch(req_ch), .req_ack(req_ack), .req_res(req_res),
    .scan_done(scan_done), .tmo_err(tmo_err)
  );

  a2d_scan_ctrl #(.NUM_CH(4), .SCAN_PERIOD(20), .TMO(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .strt_cnv(strt_b), .chnnl(ch_b),
    .cnv_cmplt(cmplt_b), .res(res_b), .rd_ch(rd_ch_b), .rd_data(rd_data_b), .vld(vld_b),
    .req(req_b), .req_ch(req_ch_b), .req_ack(req_ack_b), .req_res(req_res_b),
    .scan_done(scan_done_b), .tmo_err(tmo_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait expired, got no event, expected one", name);
  endtask

  // A2D model for the main instance: result 'base + ch' 40 cycles after start.
  int          drop_ch = -1;
  logic [11:0] base    = 12'h100;
  int          m_cnt   = 0;
  logic        m_busy  = 1'b0;
  logic [2:0]  m_ch    = '0;

  always @(negedge clk) begin
    cnv_cmplt = 1'b0;
    res       = '0;
    if (!rst_n) begin
      m_busy = 1'b0;
    end else begin
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          if (int'(m_ch) != drop_ch) begin
            cnv_cmplt = 1'b1;
            res       = base + 12'(m_ch);
          end
        end
      end
      if (strt_cnv) begin
        m_busy = 1'b1;
        m_cnt  = 40;
        m_ch   = chnnl;
      end
    end
  end

  int         mb_cnt  = 0;
  logic       mb_busy = 1'b0;
  logic [2:0] mb_ch   = '0;

  always @(negedge clk) begin
    cmplt_b = 1'b0;
    res_b   = '0;
    if (!rst_n) begin
      mb_busy = 1'b0;
    end else begin
      if (mb_busy) begin
        mb_cnt--;
        if (mb_cnt == 0) begin
          mb_busy = 1'b0;
          cmplt_b = 1'b1;
          res_b   = 12'h200 + 12'(mb_ch);
        end
      end
      if (strt_b) begin
        mb_busy = 1'b1;
        mb_cnt  = 5;
        mb_ch   = ch_b;
      end
    end
  end

  // Scoreboard: expected start channels and request results, popped on DUT events.
  int          exp_q[$];
  logic [11:0] ack_q[$];
  int          ack_cnt = 0;
  int          sd_cnt  = 0;
  int          e_ch;
  logic [11:0] e_res;

  always @(negedge clk) begin
    if (rst_n) begin
      if (strt_cnv) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL start_order: got unexpected start on ch %0d, expected none", chnnl);
        end else begin
          e_ch = exp_q.pop_front();
          check("start_order", 32'(chnnl), 32'(e_ch));
        end
      end
      if (req_ack) begin
        ack_cnt++;
        if (ack_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL req_ack: got unexpected ack res %0h, expected none", req_res);
        end else begin
          e_res = ack_q.pop_front();
          check("req_res", 32'(req_res), 32'(e_res));
        end
      end
      if (scan_done) sd_cnt++;
    end
  end

  task automatic wait_start(input int ch, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (strt_cnv && (chnnl == 3'(ch))) return;
    end
    timeout_fail($sformatf("wait_start_ch%0d", ch));
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (scan_done) return;
    end
    timeout_fail("wait_scan_done");
  endtask

  task automatic wait_ack(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (req_ack) return;
    end
    timeout_fail("wait_req_ack");
  endtask

  task automatic push_scan();
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
  endtask

  task automatic kick_scan();
    en = 1'b1;
    wait_start(0, 200);
    en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strt_cnv"},  32'(strt_cnv),  32'd0);
    check({tag, "_chnnl"},     32'(chnnl),     32'd0);
    check({tag, "_vld"},       32'(vld),       32'd0);
    check({tag, "_req_ack"},   32'(req_ack),   32'd0);
    check({tag, "_req_res"},   32'(req_res),   32'd0);
    check({tag, "_scan_done"}, 32'(scan_done), 32'd0);
    check({tag, "_tmo_err"},   32'(tmo_err),   32'd0);
    check({tag, "_rd_data"},   32'(rd_data),   32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_vec_t vecs_a[8];
    rd_vec_t vecs_b[6];
    int      n;

    for (int i = 0; i < 8; i++) begin
      vecs_a[i].ch   = 3'(i);
      vecs_a[i].data = 12'h100 + 12'(i);
    end
    vecs_b[0] = '{3'd0, 12'h200};
    vecs_b[1] = '{3'd1, 12'h201};
    vecs_b[2] = '{3'd2, 12'h202};
    vecs_b[3] = '{3'd3, 12'h203};
    vecs_b[4] = '{3'd4, 12'h000};
    vecs_b[5] = '{3'd7, 12'h000};

    rst_n = 1'b0; en = 1'b0; req = 1'b0; req_ch = '0; rd_ch = 3'd5;
    en_b  = 1'b0; req_b = 1'b0; req_ch_b = '0; rd_ch_b = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Full scan of all eight channels
    sd_cnt = 0;
    push_scan();
    kick_scan();
    wait_done(600);
    repeat (5) @(negedge clk);
    check("scan_done_count", 32'(sd_cnt), 32'd1);
    check("scan_vld", 32'(vld), 32'hFF);
    for (int i = 0; i < 8; i++) begin
      rd_ch = vecs_a[i].ch;
      #1;
      check($sformatf("table_ch%0d", i), 32'(rd_data), 32'(vecs_a[i].data));
    end

    // Request interleaved between scan channels 2 and 3
    sd_cnt = 0;
    ack_cnt = 0;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(5);
    for (int i = 3; i < 8; i++) exp_q.push_back(i);
    kick_scan();
    wait_start(2, 200);
    req = 1'b1; req_ch = 3'd5;
    ack_q.push_back(12'h1A5);
    wait_start(5, 200);
    base = 12'h1A0;
    req_ch = 3'd6;
    wait_ack(200);
    req = 1'b0;
    base = 12'h100;
    rd_ch = 3'd5;
    #1;
    check("req_table_untouched", 32'(rd_data), 32'h105);
    wait_done(600);
    repeat (5) @(negedge clk);
    check("req_ack_count", 32'(ack_cnt), 32'd1);
    check("interleave_done_count", 32'(sd_cnt), 32'd1);
    check("interleave_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while channel 6 is converting
    push_scan();
    kick_scan();
    wait_start(6, 600);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    rd_ch = 3'd6;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Timeout on channel 3; scan restarts at channel 0 after the reset
    drop_ch = 3;
    sd_cnt = 0;
    push_scan();
    kick_scan();
    wait_start(3, 400);
    n = 0;
    while (n < 2200 && !tmo_err) begin
      @(negedge clk);
      n++;
    end
    check("tmo_latency_ok", 32'((n >= 2048) && (n <= 2050)), 32'd1);
    check("tmo_err_set", 32'(tmo_err), 32'd1);
    wait_done(600);
    repeat (5) @(negedge clk);
    check("tmo_vld", 32'(vld), 32'hF7);
    rd_ch = 3'd3;
    #1;
    check("tmo_table_ch3", 32'(rd_data), 32'h000);
    rd_ch = 3'd4;
    #1;
    check("tmo_table_ch4", 32'(rd_data), 32'h104);
    check("tmo_done_count", 32'(sd_cnt), 32'd1);
    drop_ch = -1;

    // Overrun: period shorter than a scan gives exactly one back-to-back rescan
    sd_cnt = 0;
    push_scan();
    push_scan();
    en = 1'b1;
    wait_start(0, 200);
    wait_done(600);
    wait_start(0, 5);
    en = 1'b0;
    wait_done(600);
    repeat (300) @(negedge clk);
    check("overrun_done_count", 32'(sd_cnt), 32'd2);
    check("overrun_queue_empty", 32'(exp_q.size()), 32'd0);
    check("tmo_err_sticky", 32'(tmo_err), 32'd1);

    // Four-channel instance: read port beyond NUM_CH returns zero
    en_b = 1'b1;
    n = 0;
    while (n < 200 && !strt_b) begin
      @(negedge clk);
      n++;
    end
    en_b = 1'b0;
    n = 0;
    while (n < 200 && !scan_done_b) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout_fail("b_scan_done");
    repeat (3) @(negedge clk);
    check("b_vld", 32'(vld_b), 32'h0F);
    for (int i = 0; i < 6; i++) begin
      rd_ch_b = vecs_b[i].ch;
      #1;
      check($sformatf("b_table_rd%0d", vecs_b[i].ch), 32'(rd_data_b), 32'(vecs_b[i].data));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/a2d_scan_ctrl.md
A2D_SCAN_CTRL -- requirements
Module: a2d_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of channels scanned (0..NUM_CH-1); legal range 1..8.
REQ-002 SHALL have parameter SCAN_PERIOD, default 50000, clk cycles between successive scan starts.
REQ-003 SHALL have parameter TMO, default 2048, maximum clk cycles from strt_cnv to cnv_cmplt.
REQ-004 SHALL have ports clk in 1 (system clock, one clock domain) and rst_n in 1 (asynchronous, active-low reset).
REQ-005 SHALL have port en in 1: enables periodic scanning.
REQ-006 SHALL have ports strt_cnv out 1 (conversion start pulse) and chnnl out 3 (channel to convert), both to the A2D interface.
REQ-007 SHALL have ports cnv_cmplt in 1 (one-cycle completion pulse) and res in 12 (result, valid while cnv_cmplt is high), both from the A2D interface.
REQ-008 SHALL have ports rd_ch in 3, rd_data out 12 and vld out 8: result-table read port, with vld[i] meaning channel i holds a valid result.
REQ-009 SHALL have ports req in 1, req_ch in 3, req_ack out 1 and req_res out 12: on-demand single-conversion request, with a one-cycle acknowledge and its result.
REQ-010 SHALL have ports scan_done out 1 (one-cycle pulse, full scan finished) and tmo_err out 1 (sticky timeout flag).

Function
REQ-011 SHALL implement states IDLE, START, WAIT_CC, NEXT.
REQ-012 SHALL run a period counter only while en=1: counts 0..SCAN_PERIOD-1, then wraps; the wrap sets a pending-scan flag.
REQ-013 IDLE -> START: if req=1, the request is serviced first; otherwise a pending scan starts at channel 0 and clears the flag.
REQ-014 START SHALL assert strt_cnv for exactly one cycle with chnnl stable, then go to WAIT_CC.
REQ-015 chnnl SHALL stay stable from START until the cycle after cnv_cmplt.
REQ-016 WAIT_CC on cnv_cmplt SHALL do the following, then go to NEXT.
- Scan conversion: write res to table[chnnl] and set vld[chnnl].
- Request conversion: drive req_res=res and pulse req_ack; the table is not written.
REQ-017 NEXT priority, highest first:
- req=1 -> START with the request channel.
- Scan in progress and channel < NUM_CH-1 -> increment channel, START.
- Last channel done -> pulse scan_done, IDLE.
- Otherwise -> IDLE.
REQ-018 SHALL capture req_ch when the request is accepted (entry to START) and ignore later changes; req SHALL be held by the requester until req_ack.
REQ-019 A request arriving mid-scan SHALL be interleaved between scan channels without restarting or skipping scan channels.
REQ-020 A period wrap during an active scan SHALL set the pending flag; multiple wraps SHALL collapse into one pending scan.
REQ-021 SHALL count WAIT_CC cycles and, on reaching TMO, set tmo_err, leave the table entry unchanged, and proceed as if completed.
- A timed-out request SHALL still pulse req_ack, with req_res=12'h000.
REQ-022 tmo_err SHALL be cleared only by reset.
REQ-023 Deasserting en SHALL let an in-progress scan finish, clear the pending flag and hold the period counter at 0.
REQ-024 rd_data SHALL be combinational table[rd_ch]; if rd_ch >= NUM_CH, rd_data=12'h000.
REQ-025 cnv_cmplt outside WAIT_CC SHALL be ignored.

Reset
REQ-026 On rst_n low: state=IDLE, strt_cnv=0, chnnl=0, table=0, vld=0, req_ack=0, req_res=0, scan_done=0, tmo_err=0, counters=0, pending=0.
REQ-027 Reset mid-conversion SHALL abort immediately with no partial table write.

Structure
REQ-028 State enum, NUM_CH/SCAN_PERIOD/TMO defaults and the 12-bit result width SHALL live in shared package a2d_pkg.
REQ-029 The period counter SHALL be sub-module scan_timer (en, wrap pulse); the FSM and table stay in a2d_scan_ctrl.

Verification
REQ-030 Scan: en=1, SCAN_PERIOD=100, A2D model returns 12'h100+ch after 40 cycles -> strt_cnv ch0..7 in order, table[i]=12'h100+i, vld=8'hFF, one scan_done.
REQ-031 Interleave: req=1 with req_ch=5 during ch2 conversion -> order ch2, req5, ch3; req_ack once, with req_res=model value; table[5] unchanged by the request.
REQ-032 Timeout: model drops cnv_cmplt on ch3, TMO=2048 -> tmo_err=1 after 2048 cycles, vld[3]=0, scan continues at ch4.
REQ-033 Overrun: SCAN_PERIOD shorter than scan time -> exactly one back-to-back rescan, no lost channels.
REQ-034 Reset during WAIT_CC of ch6 -> all outputs at reset values, vld=0, next scan restarts at ch0.
REQ-035 Read port: rd_ch=7 with NUM_CH=4 -> rd_data=12'h000, vld[7:4]=0.
